bin2bcd_div_seq: RTL and testbench

//   Parametrised, handshaked binary-to-packed-BCD converter; successor to the fixed 14-bit/4-digit converter.

---
 rtl/bin2bcd_div_seq_pkg.sv | 26 ++
 rtl/bin2bcd_div_seq_div10_stage.sv | 23 ++
 rtl/bin2bcd_div_seq.sv | 148 ++++++++++++++
 tb/tb_bin2bcd_div_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_div_seq_pkg.sv
// bin2bcd_div_seq_pkg
//   Shared definitions for the sequential binary-to-packed-BCD converter:
//   FSM state encoding, special digit codes and a constant power-of-ten
//   helper used to size the overflow bound at elaboration time.
package bin2bcd_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  // 10^n in 36 bits; 10^10 still fits, so the largest DIGITS never truncates.
  function automatic logic [35:0] pow10(input int n);
    logic [35:0] p;
    p = 36'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 36'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_div_seq_div10_stage.sv
// bin2bcd_div_seq_div10_stage
//   Combinational divide-by-ten step: splits a remainder into its quotient
//   and its least significant decimal digit.
// Parameters
//   BIN_W  width of the remainder (4..32)
// Ports
//   rem    in   BIN_W  value to split
//   quot   out  BIN_W  rem / 10
//   digit  out  4      rem % 10, always 0..9
module bin2bcd_div_seq_div10_stage #(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] rem,
  output logic [BIN_W-1:0] quot,
  output logic [3:0]       digit
);

  localparam logic [BIN_W-1:0] TEN = BIN_W'(10);

  assign quot  = rem / TEN;
  assign digit = 4'(rem % TEN);

endmodule

// File: rtl/bin2bcd_div_seq.sv
// bin2bcd_div_seq
//   Handshaked binary to packed-BCD converter. One decimal digit is peeled
//   off per clock (units first) by a divide-by-ten stage, so a conversion
//   always takes DIGITS cycles regardless of the operand value.
// Parameters
//   BIN_W   binary input width (4..32)
//   DIGITS  number of BCD digits produced (1..10)
// Ports
//   clk         in   1         rising-edge clock
//   rst_n       in   1         asynchronous active-low reset
//   in_valid    in   1         in_binary is valid
//   in_ready    out  1         converter is idle and can take a value
//   in_binary   in   BIN_W     unsigned operand
//   out_valid   out  1         packed_bcd/ovf hold a result
//   out_ready   in   1         consumer takes the result
//   packed_bcd  out  4*DIGITS  digit i at [4i+3:4i], digit 0 = units
//   ovf         out  1         operand exceeded 10^DIGITS-1 (digits saturate to 9)
// Build option
//   BCD_BLANK_EN  when defined, leading zero digits above the most
//                 significant nonzero digit are shown as 4'hF; digit 0 is
//                 never blanked and saturated results are never blanked.
module bin2bcd_div_seq
  import bin2bcd_div_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   packed_bcd,
  output logic                  ovf
);

  localparam int                OW       = 4 * DIGITS;
  localparam int                IDX_W    = $clog2(DIGITS + 1);
  localparam logic [35:0]       MAX_VAL  = pow10(DIGITS) - 36'd1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  state_t            state;
  logic [BIN_W-1:0]  rem;
  logic [IDX_W-1:0]  idx;
  logic [OW-1:0]     digs;
  logic              ovf_r;
  logic [BIN_W-1:0]  stage_quot;
  logic [3:0]        stage_digit;
  logic [OW-1:0]     next_digs;
  logic [OW-1:0]     final_bcd;
  logic              ovf_in;
`ifdef BCD_BLANK_EN
  logic              lead_zero;
`endif

  bin2bcd_div_seq_div10_stage #(
    .BIN_W (BIN_W)
  ) u_div10 (
    .rem   (rem),
    .quot  (stage_quot),
    .digit (stage_digit)
  );

  // The 36-bit compare keeps 10^DIGITS-1 exact even when it is wider than
  // the operand; when it can never be exceeded this folds to constant 0.
  assign ovf_in = (36'(in_binary) > MAX_VAL);

  // New digits enter at the top and shift down, so after DIGITS steps the
  // first (units) digit has arrived in the lowest nibble.
  assign next_digs = OW'({stage_digit, digs} >> 4);

  // Result as it will be presented: saturated on overflow, optionally with
  // leading zeros blanked.
  always_comb begin
    final_bcd = next_digs;
`ifdef BCD_BLANK_EN
    lead_zero = 1'b1;
`endif
    if (ovf_r) begin
      final_bcd = {DIGITS{BCD_NINE}};
    end
`ifdef BCD_BLANK_EN
    else begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead_zero && (next_digs[4*i +: 4] == 4'h0)) begin
          final_bcd[4*i +: 4] = BCD_BLANK;
        end else begin
          lead_zero = 1'b0;
        end
      end
    end
`endif
  end

  // Control FSM with registered handshake outputs. in_ready comes up one
  // cycle after reset release and one cycle after each output handshake,
  // so nothing is ever accepted while a result is still being offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      packed_bcd <= '0;
      ovf        <= 1'b0;
      rem        <= '0;
      idx        <= '0;
      digs       <= '0;
      ovf_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            rem      <= in_binary;
            idx      <= '0;
            ovf_r    <= ovf_in;
            in_ready <= 1'b0;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          rem  <= stage_quot;
          digs <= next_digs;
          idx  <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            packed_bcd <= final_bcd;
            ovf        <= ovf_r;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_div_seq.sv
// tb_bin2bcd_div_seq
//   Directed checks of bin2bcd_div_seq at the default size (14 bits, 4
//   digits) and at 20 bits / 6 digits: reset state, a vector table, reset
//   during a conversion, output backpressure and a randomised handshake
//   sweep over the input range against a reference conversion.
module tb_bin2bcd_div_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_binary;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] packed_bcd;
  logic        ovf;

  logic        in_valid6;
  logic        in_ready6;
  logic [19:0] in_binary6;
  logic        out_valid6;
  logic        out_ready6;
  logic [23:0] packed_bcd6;
  logic        ovf6;

  int tests_run;
  int tests_failed;

`ifdef BCD_BLANK_EN
  localparam logic [15:0] EXP_0    = 16'hFFF0;
  localparam logic [15:0] EXP_5    = 16'hFFF5;
  localparam logic [15:0] EXP_42   = 16'hFF42;
  localparam logic [23:0] EXP_65_6 = 24'hFFFF65;
`else
  localparam logic [15:0] EXP_0    = 16'h0000;
  localparam logic [15:0] EXP_5    = 16'h0005;
  localparam logic [15:0] EXP_42   = 16'h0042;
  localparam logic [23:0] EXP_65_6 = 24'h000065;
`endif

  typedef struct {
    logic [13:0] value;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  bin2bcd_div_seq #(
    .BIN_W  (14),
    .DIGITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_binary  (in_binary),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .packed_bcd (packed_bcd),
    .ovf        (ovf)
  );

  bin2bcd_div_seq #(
    .BIN_W  (20),
    .DIGITS (6)
  ) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid6),
    .in_ready   (in_ready6),
    .in_binary  (in_binary6),
    .out_valid  (out_valid6),
    .out_ready  (out_ready6),
    .packed_bcd (packed_bcd6),
    .ovf        (ovf6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference packed-BCD conversion with saturation and optional blanking.
  function automatic logic [39:0] bcd_model(input longint unsigned v, input int digits);
    logic [39:0]       r;
    longint unsigned   lim;
    longint unsigned   x;
    r   = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    lim = lim - 1;
    if (v > lim) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      x = v;
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
`ifdef BCD_BLANK_EN
      for (int i = digits - 1; i > 0; i--) begin
        if (r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else break;
      end
`endif
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One full transaction on the 4-digit instance: offer the value, measure
  // latency to out_valid, check the result, then take it.
  task automatic applyStimulus(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf, input string name);
    int cnt;
    int lat;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    checkOutput({name, "_in_ready"}, 40'(in_ready), 40'd1);
    in_valid  = 1'b1;
    in_binary = v;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput({name, "_latency"}, 40'(lat), 40'd4);
    checkOutput({name, "_bcd"}, 40'(packed_bcd), 40'(exp_bcd));
    checkOutput({name, "_ovf"}, 40'(ovf), 40'(exp_ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_out_valid_clr"}, 40'(out_valid), 40'd0);
  endtask

  task automatic run6(input logic [19:0] v, input logic [23:0] exp_bcd, input logic exp_ovf, input string name);
    int cnt;
    int lat;
    cnt = 0;
    while (!in_ready6 && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    checkOutput({name, "_in_ready"}, 40'(in_ready6), 40'd1);
    in_valid6  = 1'b1;
    in_binary6 = v;
    @(posedge clk); #1;
    in_valid6  = 1'b0;
    lat = 0;
    while (!out_valid6 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput({name, "_latency"}, 40'(lat), 40'd6);
    checkOutput({name, "_bcd"}, 40'(packed_bcd6), 40'(exp_bcd));
    checkOutput({name, "_ovf"}, 40'(ovf6), 40'(exp_ovf));
    out_ready6 = 1'b1;
    @(posedge clk); #1;
    out_ready6 = 1'b0;
  endtask

  initial begin
    logic [16:0] exp_q[$];
    logic [16:0] exp_item;
    int          n_vals;
    int          sent;
    int          recv;
    int          cycles;
    int          cnt;
    int          lat;
    logic [13:0] v;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{14'd9999,  16'h9999, 1'b0};
    vecs[1] = '{14'd10000, 16'h9999, 1'b1};
    vecs[2] = '{14'd0,     EXP_0,    1'b0};
    vecs[3] = '{14'd42,    EXP_42,   1'b0};
    vecs[4] = '{14'd1234,  16'h1234, 1'b0};
    vecs[5] = '{14'd16383, 16'h9999, 1'b1};
    vecs[6] = '{14'd5,     EXP_5,    1'b0};
    vecs[7] = '{14'd1000,  16'h1000, 1'b0};
    vecs[8] = '{14'd8050,  16'h8050, 1'b0};
    vecs[9] = '{14'd9990,  16'h9990, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_binary  = '0;
    out_ready  = 1'b0;
    in_valid6  = 1'b0;
    in_binary6 = '0;
    out_ready6 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 40'(in_ready), 40'd0);
    checkOutput("rst_out_valid", 40'(out_valid), 40'd0);
    checkOutput("rst_bcd", 40'(packed_bcd), 40'd0);
    checkOutput("rst_ovf", 40'(ovf), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rel_in_ready", 40'(in_ready), 40'd1);

    // 20-bit / 6-digit instance
    run6(20'd1048575, 24'h999999, 1'b1, "w6_max");
    run6(20'd999999,  24'h999999, 1'b0, "w6_999999");
    run6(20'd65,      EXP_65_6,   1'b0, "w6_65");

    // Vector table on the default instance
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].value, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Reset asserted in the second conversion cycle discards the work
    in_valid  = 1'b1;
    in_binary = 14'd1234;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 40'(out_valid), 40'd0);
    checkOutput("midrst_bcd", 40'(packed_bcd), 40'd0);
    checkOutput("midrst_in_ready", 40'(in_ready), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_rel_in_ready", 40'(in_ready), 40'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_no_result", 40'(out_valid), 40'd0);
    applyStimulus(14'd1234, 16'h1234, 1'b0, "post_rst");

    // Backpressure: result held while out_ready stays low, new input ignored
    in_valid  = 1'b1;
    in_binary = 14'd42;
    @(posedge clk); #1;
    in_binary = 14'd777;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("bp_latency", 40'(lat), 40'd4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold%0d_valid", c), 40'(out_valid), 40'd1);
      checkOutput($sformatf("bp_hold%0d_bcd", c), 40'(packed_bcd), 40'(EXP_42));
      checkOutput($sformatf("bp_hold%0d_in_ready", c), 40'(in_ready), 40'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_done_in_ready", 40'(in_ready), 40'd1);
    checkOutput("bp_done_out_valid", 40'(out_valid), 40'd0);
    checkOutput("bp_done_bcd_held", 40'(packed_bcd), 40'(EXP_42));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("bp_next_bcd", 40'(packed_bcd), bcd_model(777, 4));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Sweep with random handshakes; decisions are made on the falling edge
    // so the handshake at the following rising edge is known in advance.
    n_vals = 2342;
    sent   = 0;
    recv   = 0;
    cycles = 0;
    while (recv < n_vals && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sweep_unexpected", 40'd1, 40'd0);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput($sformatf("sweep%0d", recv), 40'({ovf, packed_bcd}), 40'(exp_item));
        end
        recv++;
      end
      v = (sent == n_vals - 1) ? 14'd16383 : 14'(sent * 7);
      in_valid  = (sent < n_vals) && ($urandom_range(0, 3) != 0);
      in_binary = in_valid ? v : 14'($urandom);
      if (in_valid && in_ready) begin
        exp_q.push_back({(v > 14'd9999), bcd_model(longint'(v), 4)[15:0]});
        sent++;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("sweep_count", 40'(recv), 40'(n_vals));
    checkOutput("sweep_leftover", 40'(exp_q.size()), 40'd0);
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    checkOutput("sweep_no_extra", 40'(cnt), 40'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
